// File: rtl/mem_pkg.sv
// Shared types and widths for the two-port memory arbiter.
package mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef enum logic {
    OWN_I,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction port and a data port onto one single-cycle memory.
// Optional instruction-starvation guard enabled by defining MEM_ARB_STARVE_EN.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              dump_req,
  output logic              mem_createdump
);

  state_t            state_reg, state_next;
  owner_t            owner_reg;
  logic              wr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              force_i;

`ifdef MEM_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_reg;

  assign force_i = i_req && (starve_cnt_reg >= CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else if (!i_req || i_gnt) begin
      starve_cnt_reg <= '0;
    end else if (d_gnt && (starve_cnt_reg < CNT_W'(STARVE_LIMIT))) begin
      starve_cnt_reg <= starve_cnt_reg + 1'b1;
    end
  end
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign force_i = 1'b0;
`endif

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    state_next     = state_reg;
    i_gnt          = 1'b0;
    d_gnt          = 1'b0;
    i_rvalid       = 1'b0;
    d_rvalid       = 1'b0;
    rdata          = '0;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_createdump = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rst_n) begin
          if (d_req && !force_i) begin
            d_gnt = 1'b1;
          end else if (i_req) begin
            i_gnt = 1'b1;
          end
          mem_createdump = dump_req && !d_gnt && !i_gnt;
        end
        if (i_gnt || d_gnt) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_enable = 1'b1;
        mem_wr     = wr_reg;
        mem_addr   = addr_reg;
        mem_wdata  = wdata_reg;
        state_next = RESP;
      end
      RESP: begin
        i_rvalid   = (owner_reg == OWN_I);
        d_rvalid   = (owner_reg == OWN_D);
        rdata      = rdata_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      owner_reg <= OWN_I;
      wr_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (d_gnt) begin
        owner_reg <= OWN_D;
        wr_reg    <= d_wr;
        addr_reg  <= d_addr;
        wdata_reg <= d_wdata;
      end else if (i_gnt) begin
        owner_reg <= OWN_I;
        wr_reg    <= 1'b0;
        addr_reg  <= i_addr;
        wdata_reg <= '0;
      end
      // Writes respond with zero data, so the capture is cleared for them.
      if (state_reg == ACCESS) begin
        rdata_reg <= wr_reg ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, reference copy and response scoreboard.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt;
  logic        i_rvalid;
  logic        d_req = 1'b0;
  logic        d_wr = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] rdata;
  logic        mem_enable;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        dump_req = 1'b0;
  logic        mem_createdump;

  int asserts = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    bit          own_d;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  logic [31:0] tb_mem[0:255];
  logic [31:0] ref_mem[0:255];

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
    .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dump_req(dump_req), .mem_createdump(mem_createdump)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = tb_mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_enable && mem_wr) tb_mem[mem_addr[7:0]] <= mem_wdata;
  end

  // Response scoreboard: every rvalid must match the oldest expected response.
  always @(negedge clk) begin
    if (i_rvalid || d_rvalid) begin
      asserts++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_rvalid: i_rvalid=%0b d_rvalid=%0b, required no response", i_rvalid, d_rvalid);
      end else begin
        mon_e = sb.pop_front();
        if ({i_rvalid, d_rvalid} !== (mon_e.own_d ? 2'b01 : 2'b10)) begin
          fails++;
          $display("FAIL rvalid_owner: {i,d}=%b, required %b", {i_rvalid, d_rvalid}, (mon_e.own_d ? 2'b01 : 2'b10));
        end else if (rdata !== mon_e.data) begin
          fails++;
          $display("FAIL rdata: got %h, required %h", rdata, mon_e.data);
        end else if (cyc !== mon_e.due) begin
          fails++;
          $display("FAIL latency: response at cycle %0d, required %0d", cyc, mon_e.due);
        end else begin
          $display("txn port=%s rdata=%h cycle=%0d ok", mon_e.own_d ? "D" : "I", rdata, cyc);
        end
      end
    end
  end

  task automatic push_exp(input bit own_d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    e.own_d = own_d;
    e.due   = cyc + 2;
    if (wr) begin
      e.data = '0;
      ref_mem[addr[7:0]] = wdata;
    end else begin
      e.data = ref_mem[addr[7:0]];
    end
    sb.push_back(e);
  endtask

  // Drives one request at a negedge and holds it until granted.
  task automatic issue(input bit own_d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    int waited = 0;
    @(negedge clk);
    if (own_d) begin
      d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    #1;
    while (!(own_d ? d_gnt : i_gnt) && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    asserts++;
    if (waited >= 20) begin
      fails++;
      $display("FAIL grant_timeout: no grant after %0d cycles, required grant", waited);
    end else begin
      push_exp(own_d, wr, addr, wdata);
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    i_req = 1'b1; d_req = 1'b1; dump_req = 1'b1; i_addr = 32'h10; d_addr = 32'h20;
    repeat (2) @(negedge clk);
    #1;
    asserts++;
    if ({i_gnt, i_rvalid, d_gnt, d_rvalid, mem_enable, mem_wr, mem_createdump} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b, required 0000000",
               {i_gnt, i_rvalid, d_gnt, d_rvalid, mem_enable, mem_wr, mem_createdump});
    end
    asserts++;
    if ({rdata, mem_addr, mem_wdata} !== 96'b0) begin
      fails++;
      $display("FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h, required all 0", rdata, mem_addr, mem_wdata);
    end
    i_req = 1'b0; d_req = 1'b0; dump_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    asserts++;
    if ({i_gnt, d_gnt, mem_enable, mem_createdump} !== 4'b0) begin
      fails++;
      $display("FAIL post_reset_idle: got %b, required 0000", {i_gnt, d_gnt, mem_enable, mem_createdump});
    end
  endtask

  task automatic test_inst_read();
    wait_idle();
    i_req = 1'b1; i_addr = 32'h10;
    #1;
    asserts++;
    if ({i_gnt, d_gnt} !== 2'b10) begin
      fails++;
      $display("FAIL inst_grant: {i_gnt,d_gnt}=%b, required 10", {i_gnt, d_gnt});
    end else begin
      push_exp(1'b0, 1'b0, 32'h10, 32'h0);
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    asserts++;
    if ({mem_enable, mem_wr, mem_addr} !== {1'b1, 1'b0, 32'h10}) begin
      fails++;
      $display("FAIL inst_access: en=%b wr=%b addr=%h, required en=1 wr=0 addr=00000010", mem_enable, mem_wr, mem_addr);
    end
    wait_idle();
  endtask

  task automatic test_data_write_read();
    issue(1'b1, 1'b1, 32'h20, 32'h12345678);
    asserts++;
    if ({mem_enable, mem_wr, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h20, 32'h12345678}) begin
      fails++;
      $display("FAIL write_access: en=%b wr=%b addr=%h wdata=%h, required 1 1 00000020 12345678",
               mem_enable, mem_wr, mem_addr, mem_wdata);
    end
    issue(1'b1, 1'b0, 32'h20, 32'h0);
    asserts++;
    if ({mem_enable, mem_wr, mem_wdata} !== {1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL read_access: en=%b wr=%b wdata=%h, required 1 0 00000000", mem_enable, mem_wr, mem_wdata);
    end
    wait_idle();
  endtask

  task automatic test_priority();
    int ngnt = 0;
    int last = -3;
    int waited = 0;
    bit exp_d;
    wait_idle();
    i_req = 1'b1; i_addr = 32'h30;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h40;
    for (int it = 0; it < 18; it++) begin
      if (it != 0) @(negedge clk);
      #1;
      if (i_gnt || d_gnt) begin
`ifdef MEM_ARB_STARVE_EN
        exp_d = ((ngnt % 5) != 4);
`else
        exp_d = 1'b1;
`endif
        asserts++;
        if ({i_gnt, d_gnt} !== (exp_d ? 2'b01 : 2'b10)) begin
          fails++;
          $display("FAIL contended_grant_%0d: {i_gnt,d_gnt}=%b, required %b", ngnt, {i_gnt, d_gnt}, (exp_d ? 2'b01 : 2'b10));
        end
        asserts++;
        if (it - last != 3) begin
          fails++;
          $display("FAIL grant_spacing_%0d: %0d cycles, required 3", ngnt, it - last);
        end
        push_exp(d_gnt, 1'b0, d_gnt ? 32'h40 : 32'h30, 32'h0);
        last = it;
        ngnt++;
      end
    end
    asserts++;
    if (ngnt != 6) begin
      fails++;
      $display("FAIL contended_grant_count: %0d, required 6", ngnt);
    end
    @(negedge clk);
    d_req = 1'b0;
    #1;
    while (!i_gnt && waited < 5) begin
      @(negedge clk); #1;
      waited++;
    end
    asserts++;
    if (!i_gnt) begin
      fails++;
      $display("FAIL inst_after_data_drop: i_gnt=%b, required 1", i_gnt);
    end else begin
      push_exp(1'b0, 1'b0, 32'h30, 32'h0);
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    wait_idle();
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h40;
    #1;
    asserts++;
    if (d_gnt !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_grant: d_gnt=%b, required 1", d_gnt);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    asserts++;
    if (mem_enable !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_access: mem_enable=%b, required 1", mem_enable);
    end
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({i_rvalid, d_rvalid, mem_enable, mem_wr, mem_addr, rdata} !== 68'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: rv=%b%b en=%b wr=%b addr=%h rdata=%h, required all 0",
               i_rvalid, d_rvalid, mem_enable, mem_wr, mem_addr, rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    i_req = 1'b1; i_addr = 32'h10;
    #1;
    asserts++;
    if (i_gnt !== 1'b1) begin
      fails++;
      $display("FAIL first_grant_after_reset: i_gnt=%b, required 1", i_gnt);
    end else begin
      push_exp(1'b0, 1'b0, 32'h10, 32'h0);
    end
    @(posedge clk); #1;
    i_req = 1'b0;
    wait_idle();
  endtask

  task automatic test_dump();
    wait_idle();
    dump_req = 1'b1;
    #1;
    asserts++;
    if (mem_createdump !== 1'b1) begin
      fails++;
      $display("FAIL dump_idle: mem_createdump=%b, required 1", mem_createdump);
    end
    @(negedge clk);
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h20;
    #1;
    asserts++;
    if ({mem_createdump, d_gnt} !== 2'b01) begin
      fails++;
      $display("FAIL dump_with_grant: {dump,d_gnt}=%b, required 01", {mem_createdump, d_gnt});
    end else begin
      push_exp(1'b1, 1'b0, 32'h20, 32'h0);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    asserts++;
    if (mem_createdump !== 1'b0) begin
      fails++;
      $display("FAIL dump_in_access: mem_createdump=%b, required 0", mem_createdump);
    end
    dump_req = 1'b0;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 1'b1, 32'h50, 32'hCAFEF00D);
    issue(1'b0, 1'b0, 32'h50, 32'h0);
    issue(1'b1, 1'b1, 32'hFF, 32'h0BADC0DE);
    issue(1'b1, 1'b0, 32'hFF, 32'h0);
    issue(1'b0, 1'b0, 32'h10, 32'h0);
    issue(1'b1, 1'b0, 32'h50, 32'h0);
    wait_idle();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]  = 32'hA000_0000 | i;
      ref_mem[i] = 32'hA000_0000 | i;
    end
    tb_mem[8'h10]  = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    test_reset();
    test_inst_read();
    test_data_write_read();
    test_priority();
    test_reset_mid();
    test_dump();
    test_back_to_back();
    asserts++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_responses: %0d outstanding, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
